// File: rtl/video_pkg.sv
// video_pkg: shared VGA timing, framebuffer geometry and fetch FSM types.
package video_pkg;
  localparam int H_VISIBLE = 640;
  localparam int V_VISIBLE = 480;
  localparam int H_TOTAL = 800;
  localparam int V_TOTAL = 525;
  localparam int FB_W = 320;
  localparam int FB_H = 240;
  localparam int PIX_BITS = 4;
  localparam int WORD_BITS = 16;
  localparam int WORDS_PER_LINE = FB_W * PIX_BITS / WORD_BITS;
  localparam int BUF_WORDS = WORDS_PER_LINE * FB_H;
  typedef logic [PIX_BITS-1:0] pixel_idx_t;
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} fetch_state_t;
endpackage

// File: rtl/fb_scanout_reader_cache.sv
// line_cache_2bank: two 80-word line banks, one write port and one registered read port.
module line_cache_2bank
  import video_pkg::*;
(
  input  logic                 clk,
  input  logic                 we,
  input  logic                 wbank,
  input  logic [6:0]           waddr,
  input  logic [WORD_BITS-1:0] wdata,
  input  logic                 rbank,
  input  logic [6:0]           raddr,
  output logic [WORD_BITS-1:0] rdata
);
  logic [WORD_BITS-1:0] mem [2][WORDS_PER_LINE];
  always_ff @(posedge clk) begin
    if (we) mem[wbank][waddr] <= wdata;
    rdata <= mem[rbank][raddr];
  end
endmodule

// File: rtl/fb_scanout_reader.sv
// fb_scanout_reader: prefetches framebuffer lines into a 2-bank cache, emits 2x-scaled pixels, owns buffer swap.
module fb_scanout_reader
  import video_pkg::*;
#(
  parameter int RD_LAT = 2
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 VGA_CE,
  input  logic [9:0]           drawx,
  input  logic [9:0]           drawy,
  input  logic                 blank,
  output logic                 FB_RD_REQ,
  output logic [15:0]          FB_RD_ADDR,
  input  logic [WORD_BITS-1:0] FB_RD_DATA,
  output logic [3:0]           PIXEL_IDX,
  output logic                 BUFFER_SEL,
  input  logic                 SWAP_REQ,
  output logic                 SWAP_ACK,
  output logic                 FETCH_ERR
);
  fetch_state_t state_q, state_d;
  logic [7:0] line_q, line_d;
  logic [6:0] issue_cnt_q, issue_cnt_d, ret_cnt_q, ret_cnt_d;
  logic [RD_LAT-1:0] vld_q, vld_d;
  logic fbuf_q, fbuf_d, buf_sel_q, buf_sel_d, ack_q, ack_d, err_q, err_d;
  logic [1:0] k_q, k_d;
  logic vis_q, vis_d;
  logic [9:0] ny;
  logic trig, start, swap, we;
  logic [WORD_BITS-1:0] rdata;
  always_comb begin
    ny = (drawy == 10'(V_TOTAL - 1)) ? 10'd0 : drawy + 10'd1;
    trig = VGA_CE && drawx == 10'(H_VISIBLE) && ny < 10'(V_VISIBLE) && !ny[0];
    start = trig && state_q == IDLE;
    swap = VGA_CE && drawy == 10'(V_VISIBLE) && drawx == 10'd0 && SWAP_REQ;
    FB_RD_REQ = state_q == FETCH;
    we = vld_q[RD_LAT-1];
    state_d = state_q == IDLE ? (trig ? FETCH : IDLE)
            : state_q == FETCH ? (issue_cnt_q == 7'(WORDS_PER_LINE - 1) ? DRAIN : FETCH)
            : (ret_cnt_q == 7'(WORDS_PER_LINE) ? IDLE : DRAIN);
    line_d = start ? ny[8:1] : line_q;
    fbuf_d = start ? buf_sel_q : fbuf_q;
    issue_cnt_d = FB_RD_REQ ? issue_cnt_q + 7'd1 : 7'd0;
    ret_cnt_d = start ? 7'd0 : ret_cnt_q + 7'(we);
    vld_d = RD_LAT'({vld_q, FB_RD_REQ});
    err_d = err_q | (trig && state_q != IDLE);
    buf_sel_d = buf_sel_q ^ swap;
    ack_d = swap;
    k_d = drawx[2:1];
    vis_d = blank;
    FB_RD_ADDR = FB_RD_REQ ? (fbuf_q ? 16'(BUF_WORDS) : 16'd0) + 16'(line_q) * 16'(WORDS_PER_LINE)
                 + 16'(issue_cnt_q) : 16'd0;
    PIXEL_IDX = vis_q ? 4'(rdata >> {~k_q, 2'b00}) : 4'd0;
    BUFFER_SEL = buf_sel_q;
    SWAP_ACK = ack_q;
    FETCH_ERR = err_q;
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      line_q <= '0;
      issue_cnt_q <= '0;
      ret_cnt_q <= '0;
      vld_q <= '0;
      fbuf_q <= 1'b0;
      buf_sel_q <= 1'b0;
      ack_q <= 1'b0;
      err_q <= 1'b0;
      k_q <= '0;
      vis_q <= 1'b0;
    end else begin
      state_q <= state_d;
      line_q <= line_d;
      issue_cnt_q <= issue_cnt_d;
      ret_cnt_q <= ret_cnt_d;
      vld_q <= vld_d;
      fbuf_q <= fbuf_d;
      buf_sel_q <= buf_sel_d;
      ack_q <= ack_d;
      err_q <= err_d;
      k_q <= k_d;
      vis_q <= vis_d;
    end
  end
  // Fetch always targets the line pair not being displayed, so the banks never collide.
  line_cache_2bank u_cache (
    .clk(CLK), .we(we), .wbank(line_q[0]), .waddr(ret_cnt_q), .wdata(FB_RD_DATA),
    .rbank(drawy[1]), .raddr(drawx[9:3]), .rdata(rdata)
  );
endmodule
